apb4_req_master: RTL and testbench
==================================

APB4_REQ_MASTER -- requirements
Module: apb4_req_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width (multiple of 8).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, ACCESS wait limit (>=1); used only with timeout compiled in.
REQ-004 SHALL provide ports as follows; one clock; reset is asynchronous and active-high:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- req_valid_i  in  1  request offered
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_addr_i  in  ADDR_WIDTH  target address
- req_write_i  in  1  1=write, 0=read
- req_wdata_i  in  DATA_WIDTH  write data
- req_strb_i  in  DATA_WIDTH/8  write byte strobes
- req_prot_i  in  3  protection attribute
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes)
- rsp_err_o  out  1  slave error or timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o  out  APB4 initiator signals
- pready_i, prdata_i, pslverr_i  in  APB4 responder signals

Function
REQ-005 SHALL implement FSM IDLE, SETUP, ACCESS, RESP; req_ready_o high only in IDLE.
REQ-006 IDLE with req_valid_i SHALL capture addr/write/wdata/strb/prot and enter SETUP next cycle.
REQ-007 SETUP SHALL drive psel_o=1, penable_o=0 for exactly one cycle, then enter ACCESS.
REQ-008 ACCESS SHALL drive psel_o=1, penable_o=1 until pready_i=1; paddr/pwrite/pwdata/pstrb/pprot SHALL stay constant from SETUP through final ACCESS cycle.
REQ-009 pstrb_o SHALL be all-zero for reads regardless of req_strb_i.
REQ-010 On ACCESS with pready_i=1: SHALL register prdata_i (reads) or 0 (writes) into rsp_rdata_o, pslverr_i into rsp_err_o, rsp_timeout_o=0, and enter RESP.
REQ-011 RESP SHALL hold rsp_valid_o=1 and response fields stable until rsp_ready_i=1, then return to IDLE.
REQ-012 psel_o and penable_o SHALL be 0 in IDLE and RESP; other APB outputs hold last value.
REQ-013 Minimum latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid_o at N+3 with zero-wait responder; next accept no earlier than the cycle after rsp handshake.
REQ-014 All outputs SHALL be registered or decoded from the state register only; no combinational path from pready_i to any output.

Reset
REQ-015 Asserting rst_i at any time, including mid-transfer, SHALL immediately force IDLE, psel_o=0, penable_o=0, rsp_valid_o=0, and all data/address/strobe/error outputs to 0; no response is issued for an aborted transfer.

Configuration
REQ-016 With APB4_MASTER_TIMEOUT_EN defined, SHALL count consecutive ACCESS cycles with pready_i=0; when the count reaches TIMEOUT_CYCLES, SHALL deassert psel_o/penable_o next cycle, enter RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
REQ-017 If pready_i=1 in the same cycle the limit is reached, the normal completion SHALL win.
REQ-018 Counter SHALL clear on entry to SETUP; width $clog2(TIMEOUT_CYCLES+1).
REQ-019 Without APB4_MASTER_TIMEOUT_EN, ACCESS SHALL wait indefinitely, rsp_timeout_o SHALL be tied 0, and no counter logic SHALL exist.

Structure
REQ-020 Package apb4_master_pkg SHALL hold the FSM state enum, APB4 pprot bit constants, and a default TIMEOUT constant.
REQ-021 Timeout counter SHALL be sub-module apb4_timeout_cnt (clear, enable, limit, expired), instantiated only under the macro.

Verification
REQ-022 Write addr=0x0000_0010, wdata=0xDEAD_BEEF, strb=0xF, pready=1 -> SETUP then one ACCESS cycle with stable signals, rsp_valid at accept+3, rsp_err=0, rsp_rdata=0.
REQ-023 Read addr=0x0000_000C, pready low 3 cycles then high with prdata=0x1234_5678 -> 4 ACCESS cycles, rsp_rdata=0x1234_5678, pstrb=0 throughout.
REQ-024 Write with pslverr=1 on completion, rsp_ready held low 5 cycles -> rsp_valid and rsp_err=1 held stable 5 cycles, req_ready low until after handshake.
REQ-025 Macro on, TIMEOUT_CYCLES=4, pready never high -> exactly 4 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1; variant with pready=1 on 4th cycle -> normal completion, rsp_timeout=0.
REQ-026 rst_i pulsed during ACCESS -> psel/penable low in same cycle, no rsp_valid; next request completes normally.

Source files
------------

// File: rtl/apb4_master_pkg.sv
// Shared definitions for the APB4 request master: sequencer states, pprot bits
// and the default ACCESS wait limit.
package apb4_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam logic [2:0] PPROT_PRIVILEGED  = 3'b001;
    localparam logic [2:0] PPROT_NONSECURE   = 3'b010;
    localparam logic [2:0] PPROT_INSTRUCTION = 3'b100;

    localparam int DEFAULT_TIMEOUT = 32'sd256;

endpackage

// File: rtl/apb4_req_master_if.sv
// Request/response and APB4 signal bundle for apb4_req_master. The master
// modport is the block's view; the slave modport is the surrounding system.
interface apb4_req_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic                  req_write_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic [STRB_WIDTH-1:0] req_strb_i;
    logic [2:0]            req_prot_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  rsp_timeout_o;

    logic [ADDR_WIDTH-1:0] paddr_o;
    logic [2:0]            pprot_o;
    logic                  psel_o;
    logic                  penable_o;
    logic                  pwrite_o;
    logic [DATA_WIDTH-1:0] pwdata_o;
    logic [STRB_WIDTH-1:0] pstrb_o;
    logic                  pready_i;
    logic [DATA_WIDTH-1:0] prdata_i;
    logic                  pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  rsp_ready_i,
        output paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        input  pready_i, prdata_i, pslverr_i
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output rsp_ready_i,
        input  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
        output pready_i, prdata_i, pslverr_i
    );

endinterface

// File: rtl/apb4_timeout_cnt.sv
// Consecutive wait-state counter for the APB4 ACCESS phase; expired_o marks the
// wait cycle that brings the count up to limit_i.
module apb4_timeout_cnt #(
    parameter int CNT_WIDTH = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output logic                 expired_o
);

    logic [CNT_WIDTH-1:0] cnt_r;

    // Wait-cycle count, saturating at the limit so it cannot wrap.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (clear_i) begin
            cnt_r <= '0;
        end else if (enable_i && (cnt_r != limit_i)) begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
        end
    end

    assign expired_o = enable_i && ((cnt_r + CNT_WIDTH'(1)) == limit_i);

endmodule

// File: rtl/apb4_req_master.sv
// APB4 initiator that turns one valid/ready request into one APB transfer and a
// held response. Define APB4_MASTER_TIMEOUT_EN to bound the ACCESS wait.
module apb4_req_master
    import apb4_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    apb4_req_master_if.master  bus
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    apb_state_e            state_r;
    logic [ADDR_WIDTH-1:0] paddr_r;
    logic [2:0]            pprot_r;
    logic                  psel_r;
    logic                  penable_r;
    logic                  pwrite_r;
    logic [DATA_WIDTH-1:0] pwdata_r;
    logic [STRB_WIDTH-1:0] pstrb_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_rdata_r;
    logic                  rsp_err_r;
    logic                  timeout_s;

`ifdef APB4_MASTER_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic cnt_clear_s;
    logic cnt_enable_s;
    logic rsp_timeout_r;

    assign cnt_clear_s  = (state_r == ST_IDLE) && bus.req_valid_i;
    assign cnt_enable_s = (state_r == ST_ACCESS) && !bus.pready_i;

    apb4_timeout_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timeout_cnt (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (cnt_clear_s),
        .enable_i  (cnt_enable_s),
        .limit_i   (CNT_WIDTH'(TIMEOUT_CYCLES)),
        .expired_o (timeout_s)
    );

    // Timeout flag follows the way the last ACCESS phase ended; pready wins a tie.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_timeout_r <= 1'b0;
        end else if (state_r == ST_ACCESS) begin
            if (bus.pready_i) begin
                rsp_timeout_r <= 1'b0;
            end else if (timeout_s) begin
                rsp_timeout_r <= 1'b1;
            end
        end
    end

    assign bus.rsp_timeout_o = rsp_timeout_r;
`else
    assign timeout_s         = 1'b0;
    assign bus.rsp_timeout_o = 1'b0;
`endif

    // Transfer sequencer; every bus and response output is loaded here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            paddr_r     <= '0;
            pprot_r     <= 3'b000;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            pwdata_r    <= '0;
            pstrb_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid_i) begin
                        paddr_r   <= bus.req_addr_i;
                        pprot_r   <= bus.req_prot_i;
                        pwrite_r  <= bus.req_write_i;
                        pwdata_r  <= bus.req_wdata_i;
                        pstrb_r   <= bus.req_write_i ? bus.req_strb_i : '0;
                        psel_r    <= 1'b1;
                        penable_r <= 1'b0;
                        state_r   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.pready_i) begin
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= pwrite_r ? '0 : bus.prdata_i;
                        rsp_err_r   <= bus.pslverr_i;
                        state_r     <= ST_RESP;
                    end else if (timeout_s) begin
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= '0;
                        rsp_err_r   <= 1'b1;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = (state_r == ST_IDLE);
    assign bus.paddr_o     = paddr_r;
    assign bus.pprot_o     = pprot_r;
    assign bus.psel_o      = psel_r;
    assign bus.penable_o   = penable_r;
    assign bus.pwrite_o    = pwrite_r;
    assign bus.pwdata_o    = pwdata_r;
    assign bus.pstrb_o     = pstrb_r;
    assign bus.rsp_valid_o = rsp_valid_r;
    assign bus.rsp_rdata_o = rsp_rdata_r;
    assign bus.rsp_err_o   = rsp_err_r;

endmodule

// File: tb/tb_apb4_req_master.sv
// Self-checking bench for apb4_req_master: a transaction-level model predicts
// every output each cycle, directed transfers pin latencies and data literally.
module tb_apb4_req_master;
    import apb4_master_pkg::*;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int TO_CYC = 4;
`ifdef APB4_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    apb4_req_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb4_req_master #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: m_age counts cycles since acceptance (1 = setup cycle,
    // k+1 = k-th access cycle); a response is held until consumed.
    bit            m_active = 1'b0;
    int            m_age    = 0;
    bit            m_rsp    = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic          m_write  = 1'b0;
    logic [DW-1:0] m_wdata  = '0;
    logic [SW-1:0] m_strb   = '0;
    logic [2:0]    m_prot   = 3'b000;
    logic [DW-1:0] m_rdata  = '0;
    logic          m_err    = 1'b0;
    logic          m_to     = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_age = 0; m_rsp = 1'b0;
            m_addr = '0; m_write = 1'b0; m_wdata = '0; m_strb = '0; m_prot = 3'b000;
            m_rdata = '0; m_err = 1'b0; m_to = 1'b0;
        end else if (m_rsp) begin
            if (bus.rsp_ready_i) m_rsp = 1'b0;
        end else if (m_active) begin
            if (m_age >= 2 && bus.pready_i) begin
                m_rdata = m_write ? '0 : bus.prdata_i;
                m_err = bus.pslverr_i; m_to = 1'b0;
                m_active = 1'b0; m_rsp = 1'b1;
            end else if (TO_EN && (m_age - 1) == TO_CYC) begin
                m_rdata = '0; m_err = 1'b1; m_to = 1'b1;
                m_active = 1'b0; m_rsp = 1'b1;
            end else begin
                m_age++;
            end
        end else if (bus.req_valid_i) begin
            m_addr = bus.req_addr_i; m_write = bus.req_write_i; m_wdata = bus.req_wdata_i;
            m_strb = bus.req_write_i ? bus.req_strb_i : '0; m_prot = bus.req_prot_i;
            m_active = 1'b1; m_age = 1;
        end
    end

    // Compare every DUT output against the model away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", bus.req_ready_o, !m_active && !m_rsp);
            chk("psel", bus.psel_o, m_active);
            chk("penable", bus.penable_o, m_active && m_age >= 2);
            chk("paddr", bus.paddr_o, m_addr);
            chk("pwrite", bus.pwrite_o, m_write);
            chk("pwdata", bus.pwdata_o, m_wdata);
            chk("pstrb", bus.pstrb_o, m_strb);
            chk("pprot", bus.pprot_o, m_prot);
            chk("rsp_valid", bus.rsp_valid_o, m_rsp);
            chk("rsp_rdata", bus.rsp_rdata_o, m_rdata);
            chk("rsp_err", bus.rsp_err_o, m_err);
            chk("rsp_timeout", bus.rsp_timeout_o, m_to);
        end
    end

    // wait_n < 0: responder never raises pready.
    task automatic run_txn(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                           input logic [SW-1:0] strb, input logic [2:0] prot, input int wait_n,
                           input logic [DW-1:0] rdata, input logic slverr, input int hold,
                           output int acc, output int lat, output logic [DW-1:0] r_data,
                           output logic r_err, output logic r_to);
        int n0;
        bit got;
        acc = 0; lat = -1; got = 1'b0; r_data = '0; r_err = 1'b0; r_to = 1'b0;
        @(posedge clk); #2;
        bus.req_valid_i = 1'b1; bus.req_addr_i = addr; bus.req_write_i = wr;
        bus.req_wdata_i = wdata; bus.req_strb_i = strb; bus.req_prot_i = prot;
        n0 = cyc;
        @(posedge clk); #2;
        bus.req_valid_i = 1'b0;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            bus.pready_i = 1'b0; bus.pslverr_i = 1'b0;
            if (bus.rsp_valid_o) begin
                got = 1'b1; lat = cyc - n0;
                r_data = bus.rsp_rdata_o; r_err = bus.rsp_err_o; r_to = bus.rsp_timeout_o;
            end else if (bus.psel_o && bus.penable_o) begin
                acc++;
                if (!wr) chk("pstrb_read_zero", bus.pstrb_o, 64'd0);
                if (wait_n >= 0 && acc > wait_n) begin
                    bus.pready_i = 1'b1; bus.prdata_i = rdata; bus.pslverr_i = slverr;
                end else begin
                    bus.prdata_i = 32'hBAD0_0000 | 32'(acc); bus.pslverr_i = 1'b1;
                end
            end
        end
        chk("rsp_arrived", got, 64'd1);
        for (int h = 0; h < hold; h++) begin
            chk("hold_rsp_valid", bus.rsp_valid_o, 64'd1);
            chk("hold_req_ready", bus.req_ready_o, 64'd0);
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #2;
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        chk("post_hs_req_ready", bus.req_ready_o, 64'd1);
        chk("post_hs_rsp_valid", bus.rsp_valid_o, 64'd0);
    endtask

    int            acc;
    int            lat;
    logic [DW-1:0] r_data;
    logic          r_err;
    logic          r_to;

    initial begin
        bus.req_valid_i = 1'b0; bus.req_addr_i = '0; bus.req_write_i = 1'b0;
        bus.req_wdata_i = '0; bus.req_strb_i = '0; bus.req_prot_i = 3'b000;
        bus.rsp_ready_i = 1'b0; bus.pready_i = 1'b0; bus.prdata_i = '0; bus.pslverr_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", bus.req_ready_o, 64'd1);
        chk("reset_psel", bus.psel_o, 64'd0);
        chk("reset_rsp_valid", bus.rsp_valid_o, 64'd0);
        chk("reset_paddr", bus.paddr_o, 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        chk_en = 1'b1;

        // Zero-wait write.
        run_txn(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, PPROT_NONSECURE, 0, 32'h0, 1'b0, 0,
                acc, lat, r_data, r_err, r_to);
        chk("wr_latency", lat, 64'd3);
        chk("wr_access_cycles", acc, 64'd1);
        chk("wr_rdata", r_data, 64'd0);
        chk("wr_err", r_err, 64'd0);

        // Read with three wait states; strobes offered must not reach pstrb.
        run_txn(32'h0000_000C, 1'b0, 32'h5555_AAAA, 4'hF, 3'b000, 3, 32'h1234_5678, 1'b0, 0,
                acc, lat, r_data, r_err, r_to);
        chk("rd_access_cycles", acc, 64'd4);
        chk("rd_latency", lat, 64'd6);
        chk("rd_rdata", r_data, 64'h1234_5678);
        chk("rd_err", r_err, 64'd0);

        // Erroring write with a slow response consumer.
        run_txn(32'h0000_0100, 1'b1, 32'h0BAD_F00D, 4'h3, PPROT_PRIVILEGED, 0, 32'hFFFF_FFFF, 1'b1, 5,
                acc, lat, r_data, r_err, r_to);
        chk("slverr_err", r_err, 64'd1);
        chk("slverr_rdata", r_data, 64'd0);
        chk("slverr_latency", lat, 64'd3);

`ifdef APB4_MASTER_TIMEOUT_EN
        run_txn(32'h0000_0200, 1'b0, 32'h0, 4'h0, 3'b000, -1, 32'h0, 1'b0, 0,
                acc, lat, r_data, r_err, r_to);
        chk("to_access_cycles", acc, 64'd4);
        chk("to_latency", lat, 64'd6);
        chk("to_err", r_err, 64'd1);
        chk("to_flag", r_to, 64'd1);
        chk("to_rdata", r_data, 64'd0);

        run_txn(32'h0000_0204, 1'b0, 32'h0, 4'h0, 3'b000, 3, 32'hCAFE_0004, 1'b0, 0,
                acc, lat, r_data, r_err, r_to);
        chk("to_tie_access_cycles", acc, 64'd4);
        chk("to_tie_flag", r_to, 64'd0);
        chk("to_tie_err", r_err, 64'd0);
        chk("to_tie_rdata", r_data, 64'hCAFE_0004);
`else
        run_txn(32'h0000_0200, 1'b0, 32'h0, 4'h0, 3'b000, 6, 32'hCAFE_0007, 1'b0, 0,
                acc, lat, r_data, r_err, r_to);
        chk("long_wait_access_cycles", acc, 64'd7);
        chk("long_wait_latency", lat, 64'd9);
        chk("long_wait_flag", r_to, 64'd0);
        chk("long_wait_rdata", r_data, 64'hCAFE_0007);
`endif

        // Reset pulse in the middle of an ACCESS phase.
        @(posedge clk); #2;
        bus.req_valid_i = 1'b1; bus.req_addr_i = 32'h0000_0020; bus.req_write_i = 1'b1;
        bus.req_wdata_i = 32'h1111_2222; bus.req_strb_i = 4'hC; bus.req_prot_i = 3'b010;
        @(posedge clk); #2;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_penable", bus.penable_o, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_psel", bus.psel_o, 64'd0);
        chk("rst_penable", bus.penable_o, 64'd0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 64'd0);
        chk("rst_paddr", bus.paddr_o, 64'd0);
        chk("rst_pwdata", bus.pwdata_o, 64'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", bus.rsp_valid_o, 64'd0);
        end

        run_txn(32'h0000_0040, 1'b0, 32'h0, 4'hA, PPROT_PRIVILEGED | PPROT_INSTRUCTION, 0,
                32'h89AB_CDEF, 1'b0, 1, acc, lat, r_data, r_err, r_to);
        chk("after_rst_latency", lat, 64'd3);
        chk("after_rst_rdata", r_data, 64'h89AB_CDEF);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
